// File: rtl/lsu_bus_if.sv
// lsu_bus_if -- signal bundle around the load/store unit.
//
// Groups three links that meet at the LSU:
//   execute -> LSU    : ex_lsu_* op fields, ex_flush, ex_lsu_valid / lsu_ex_ready
//   LSU -> writeback  : lsu_wb_* results, lsu_wb_valid / wb_lsu_ready
//   LSU <-> memory    : mem_req_* / mem_resp_*
// plus the hazard taps lsu_ex_forward_* for the held op.
//
// Modports:
//   master -- the LSU view (drives the ready/valid outputs and the bus request)
//   slave  -- the surrounding pipeline and memory view
//
// Handshake rule on every link: a transfer happens on a rising clk edge
// where valid and ready are both 1. Once valid is raised, the payload is
// held stable and valid is not dropped until that transfer, except for a
// flush or reset.
interface lsu_bus_if #(
   parameter int XLEN = 32
);
   // execute -> LSU
   logic            ex_lsu_valid;
   logic            lsu_ex_ready;
   logic            ex_lsu_MemRead;
   logic            ex_lsu_MemWrite;
   logic            ex_lsu_RegWrite;
   logic [2:0]      ex_lsu_MemLen;
   logic [4:0]      ex_lsu_rd;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] data_in;
   logic [XLEN-1:0] ex_lsu_result;
   logic [XLEN-1:0] ex_lsu_pc;
   logic [XLEN-1:0] ex_lsu_inst;
   logic            ex_flush;

   // LSU -> writeback
   logic            lsu_wb_valid;
   logic            wb_lsu_ready;
   logic            lsu_wb_RegWrite;
   logic [4:0]      lsu_wb_rd;
   logic [XLEN-1:0] lsu_wb_write_rd_data;
   logic [XLEN-1:0] lsu_wb_pc;
   logic [XLEN-1:0] lsu_wb_inst;
   logic            lsu_wb_exc;
   logic [3:0]      lsu_wb_cause;
   logic [XLEN-1:0] lsu_wb_tval;

   // memory bus
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_we;
   logic [XLEN-1:0] mem_req_addr;
   logic [XLEN-1:0] mem_req_wdata;
   logic [3:0]      mem_req_wstrb;
   logic            mem_resp_valid;
   logic            mem_resp_ready;
   logic [XLEN-1:0] mem_resp_rdata;
   logic            mem_resp_err;

   // hazard taps
   logic [4:0]      lsu_ex_forward_rd;
   logic            lsu_ex_forward_RegWrite;
   logic            lsu_ex_forward_MemRead;

   modport master (
      input  ex_lsu_valid, ex_lsu_MemRead, ex_lsu_MemWrite, ex_lsu_RegWrite,
             ex_lsu_MemLen, ex_lsu_rd, addr, data_in, ex_lsu_result,
             ex_lsu_pc, ex_lsu_inst, ex_flush, wb_lsu_ready,
             mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
      output lsu_ex_ready, lsu_wb_valid, lsu_wb_RegWrite, lsu_wb_rd,
             lsu_wb_write_rd_data, lsu_wb_pc, lsu_wb_inst, lsu_wb_exc,
             lsu_wb_cause, lsu_wb_tval, mem_req_valid, mem_req_we,
             mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_resp_ready,
             lsu_ex_forward_rd, lsu_ex_forward_RegWrite, lsu_ex_forward_MemRead
   );

   modport slave (
      output ex_lsu_valid, ex_lsu_MemRead, ex_lsu_MemWrite, ex_lsu_RegWrite,
             ex_lsu_MemLen, ex_lsu_rd, addr, data_in, ex_lsu_result,
             ex_lsu_pc, ex_lsu_inst, ex_flush, wb_lsu_ready,
             mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
      input  lsu_ex_ready, lsu_wb_valid, lsu_wb_RegWrite, lsu_wb_rd,
             lsu_wb_write_rd_data, lsu_wb_pc, lsu_wb_inst, lsu_wb_exc,
             lsu_wb_cause, lsu_wb_tval, mem_req_valid, mem_req_we,
             mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_resp_ready,
             lsu_ex_forward_rd, lsu_ex_forward_RegWrite, lsu_ex_forward_MemRead
   );
endinterface

// File: rtl/lsu_bus.sv
// lsu_bus -- single-entry load/store stage between execute and writeback.
//
// Holds one op at a time. Non-memory ops pass straight to DONE. Loads and
// stores issue one word-aligned bus request, wait for the response, align
// and extend the load data, then present the result to writeback. Misaligned
// or illegal-length accesses trap without touching the bus.
//
// Ports:
//   clk       -- single clock, all state on the rising edge
//   rst       -- synchronous, active-high reset
//   bus       -- lsu_bus_if.master: execute, writeback and memory links
//   dbg_state -- current FSM state (0 IDLE, 1 REQ, 2 RESP, 3 DONE)
//
// Parameters:
//   XLEN        -- data/address width, 32 only
//   ALIGN_CHECK -- 1: misaligned access traps, 0: issued unchanged
module lsu_bus #(
   parameter int XLEN        = 32,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   lsu_bus_if.master   bus,
   output logic [1:0]  dbg_state
);

   generate
      if (XLEN != 32) begin : g_xlen_check
         $error("lsu_bus: only XLEN=32 is supported");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state;

   // held op
   logic            op_load;
   logic            op_store;
   logic            op_regwrite;
   logic [4:0]      op_rd;
   logic [2:0]      op_len;
   logic [1:0]      op_off;
   logic [XLEN-1:0] op_addr;
   // set when a flush lands after the bus has taken the request; the
   // response is still absorbed but nothing reaches writeback
   logic            killed;

   // registered outputs
   logic            req_we;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [3:0]      req_wstrb;
   logic            wb_regwrite;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [XLEN-1:0] wb_pc;
   logic [XLEN-1:0] wb_inst;
   logic            wb_exc;
   logic [3:0]      wb_cause;
   logic [XLEN-1:0] wb_tval;

   // decode of the incoming op
   logic            is_mem;
   logic            len_legal;
   logic            misaligned;
   logic            take_exc;
   logic            ready_c;
   logic            take;
   logic [3:0]      strb_base;
   logic [3:0]      wstrb_c;
   logic [XLEN-1:0] wdata_c;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_data;
   logic            live;

   always_comb begin
      is_mem     = bus.ex_lsu_MemRead | bus.ex_lsu_MemWrite;
      len_legal  = 1'b0;
      misaligned = 1'b0;
      strb_base  = 4'b0001;
      case (bus.ex_lsu_MemLen)
         3'b000, 3'b100: begin
            len_legal = 1'b1;
            strb_base = 4'b0001;
         end
         3'b001, 3'b101: begin
            len_legal  = 1'b1;
            strb_base  = 4'b0011;
            misaligned = bus.addr[0];
         end
         3'b010: begin
            len_legal  = 1'b1;
            strb_base  = 4'b1111;
            misaligned = |bus.addr[1:0];
         end
         default: ;
      endcase
      // an illegal length traps even with alignment checking disabled
      take_exc = is_mem & (~len_legal | (ALIGN_CHECK & misaligned));
      wstrb_c  = strb_base << bus.addr[1:0];
      wdata_c  = bus.data_in << {bus.addr[1:0], 3'b000};

      ready_c = (state == IDLE) | ((state == DONE) & bus.wb_lsu_ready);
      // a flush in DONE kills the upstream op along with the held one
      take    = bus.ex_lsu_valid & ready_c & ~((state == DONE) & bus.ex_flush);

      shifted = bus.mem_resp_rdata >> {op_off, 3'b000};
      case (op_len)
         3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_data = shifted;
      endcase

      live = ((state == REQ) | (state == RESP)) & ~killed;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_load     <= 1'b0;
         op_store    <= 1'b0;
         op_regwrite <= 1'b0;
         op_rd       <= '0;
         op_len      <= '0;
         op_off      <= '0;
         op_addr     <= '0;
         killed      <= 1'b0;
         req_we      <= 1'b0;
         req_addr    <= '0;
         req_wdata   <= '0;
         req_wstrb   <= '0;
         wb_regwrite <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         wb_pc       <= '0;
         wb_inst     <= '0;
         wb_exc      <= 1'b0;
         wb_cause    <= '0;
         wb_tval     <= '0;
      end else begin
         case (state)
            REQ: begin
               if (bus.mem_req_ready) begin
                  // the bus owns the request now; a flush must wait for its response
                  state  <= RESP;
                  killed <= bus.ex_flush;
               end else if (bus.ex_flush) begin
                  state <= IDLE;
               end
            end
            RESP: begin
               if (bus.mem_resp_valid) begin
                  if (killed | bus.ex_flush) begin
                     state  <= IDLE;
                     killed <= 1'b0;
                  end else begin
                     state <= DONE;
                     if (bus.mem_resp_err) begin
                        wb_regwrite <= 1'b0;
                        wb_data     <= '0;
                        wb_exc      <= 1'b1;
                        wb_cause    <= op_store ? 4'd7 : 4'd5;
                        wb_tval     <= op_addr;
                     end else begin
                        wb_regwrite <= op_load & op_regwrite;
                        wb_data     <= op_load ? load_data : '0;
                        wb_exc      <= 1'b0;
                        wb_cause    <= '0;
                        wb_tval     <= '0;
                     end
                  end
               end else if (bus.ex_flush) begin
                  killed <= 1'b1;
               end
            end
            DONE: begin
               if (bus.ex_flush | bus.wb_lsu_ready) begin
                  state <= IDLE;
               end
            end
            default: ;
         endcase

         // capture overrides the IDLE fall-through above when a new op arrives
         if (take) begin
            op_load     <= bus.ex_lsu_MemRead & ~bus.ex_lsu_MemWrite;
            op_store    <= bus.ex_lsu_MemWrite;
            op_regwrite <= bus.ex_lsu_RegWrite;
            op_rd       <= bus.ex_lsu_rd;
            op_len      <= bus.ex_lsu_MemLen;
            op_off      <= bus.addr[1:0];
            op_addr     <= bus.addr;
            killed      <= 1'b0;
            wb_rd       <= bus.ex_lsu_rd;
            wb_pc       <= bus.ex_lsu_pc;
            wb_inst     <= bus.ex_lsu_inst;
            if (!is_mem) begin
               state       <= DONE;
               wb_regwrite <= bus.ex_lsu_RegWrite;
               wb_data     <= bus.ex_lsu_result;
               wb_exc      <= 1'b0;
               wb_cause    <= '0;
               wb_tval     <= '0;
            end else if (take_exc) begin
               state       <= DONE;
               wb_regwrite <= 1'b0;
               wb_data     <= '0;
               wb_exc      <= 1'b1;
               wb_cause    <= bus.ex_lsu_MemWrite ? 4'd6 : 4'd4;
               wb_tval     <= bus.addr;
            end else begin
               state     <= REQ;
               req_we    <= bus.ex_lsu_MemWrite;
               req_addr  <= {bus.addr[XLEN-1:2], 2'b00};
               req_wdata <= bus.ex_lsu_MemWrite ? wdata_c : '0;
               req_wstrb <= bus.ex_lsu_MemWrite ? wstrb_c : 4'b0000;
            end
         end
      end
   end

   assign dbg_state = state;

   assign bus.lsu_ex_ready         = ready_c;
   assign bus.mem_req_valid        = (state == REQ);
   assign bus.mem_req_we           = req_we;
   assign bus.mem_req_addr         = req_addr;
   assign bus.mem_req_wdata        = req_wdata;
   assign bus.mem_req_wstrb        = req_wstrb;
   assign bus.mem_resp_ready       = (state == RESP);
   assign bus.lsu_wb_valid         = (state == DONE);
   assign bus.lsu_wb_RegWrite      = wb_regwrite;
   assign bus.lsu_wb_rd            = wb_rd;
   assign bus.lsu_wb_write_rd_data = wb_data;
   assign bus.lsu_wb_pc            = wb_pc;
   assign bus.lsu_wb_inst          = wb_inst;
   assign bus.lsu_wb_exc           = wb_exc;
   assign bus.lsu_wb_cause         = wb_cause;
   assign bus.lsu_wb_tval          = wb_tval;

   assign bus.lsu_ex_forward_rd       = (live | (state == DONE)) ? op_rd : 5'd0;
   assign bus.lsu_ex_forward_RegWrite = live ? (op_regwrite & op_load)
                                             : ((state == DONE) & wb_regwrite);
   assign bus.lsu_ex_forward_MemRead  = live & op_load;

endmodule

// File: tb/tb_lsu_bus.sv
module tb_lsu_bus;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   lsu_bus_if #(.XLEN(32)) bus ();

   lsu_bus #(.XLEN(32), .ALIGN_CHECK(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   // memory responder configuration (written by the main sequence only)
   int          stall_cfg  = 0;
   logic        resp_hold  = 1'b0;
   logic [31:0] resp_data  = 32'h0;
   logic        resp_err   = 1'b0;

   // responder / monitor state (written by the negedge process only)
   int          stall_left = 0;
   logic        prev_valid = 1'b0;
   logic        prev_wait  = 1'b0;
   logic [31:0] prev_addr  = 32'h0;
   logic [31:0] prev_wdata = 32'h0;
   logic [3:0]  prev_wstrb = 4'h0;
   logic        prev_we    = 1'b0;
   int          req_valid_cycles = 0;
   int          stab_err   = 0;
   int          wb_cycles  = 0;

   // request handshake capture (written by the posedge process only)
   int          req_count  = 0;
   logic [31:0] last_addr  = 32'h0;
   logic [31:0] last_wdata = 32'h0;
   logic [3:0]  last_wstrb = 4'h0;
   logic        last_we    = 1'b0;

   // memory model: programmable stall before accepting a request,
   // response returned the cycle mem_resp_ready is seen unless held off
   always @(negedge clk) begin
      if (bus.mem_req_valid) begin
         req_valid_cycles++;
         if (prev_wait && (bus.mem_req_addr !== prev_addr || bus.mem_req_wdata !== prev_wdata ||
                           bus.mem_req_wstrb !== prev_wstrb || bus.mem_req_we !== prev_we))
            stab_err++;
         if (!prev_valid) stall_left = stall_cfg;
         prev_addr  = bus.mem_req_addr;
         prev_wdata = bus.mem_req_wdata;
         prev_wstrb = bus.mem_req_wstrb;
         prev_we    = bus.mem_req_we;
         if (stall_left > 0) begin
            bus.mem_req_ready = 1'b0;
            stall_left--;
            prev_wait = 1'b1;
         end else begin
            bus.mem_req_ready = 1'b1;
            prev_wait = 1'b0;
         end
      end else begin
         bus.mem_req_ready = 1'b0;
         prev_wait = 1'b0;
      end
      prev_valid          = bus.mem_req_valid;
      bus.mem_resp_valid  = bus.mem_resp_ready & ~resp_hold;
      bus.mem_resp_rdata  = resp_data;
      bus.mem_resp_err    = resp_err;
      if (bus.lsu_wb_valid) wb_cycles++;
   end

   always @(posedge clk) begin
      if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
         req_count++;
         last_addr  = bus.mem_req_addr;
         last_wdata = bus.mem_req_wdata;
         last_wstrb = bus.mem_req_wstrb;
         last_we    = bus.mem_req_we;
      end
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // presents one op for a single cycle; caller ensures the LSU is ready
   task automatic send(input logic rd_op, input logic wr_op, input logic regw,
                       input logic [2:0] len, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] res, input logic [31:0] pc);
      @(negedge clk);
      bus.ex_lsu_valid    = 1'b1;
      bus.ex_lsu_MemRead  = rd_op;
      bus.ex_lsu_MemWrite = wr_op;
      bus.ex_lsu_RegWrite = regw;
      bus.ex_lsu_MemLen   = len;
      bus.ex_lsu_rd       = rd;
      bus.addr            = a;
      bus.data_in         = d;
      bus.ex_lsu_result   = res;
      bus.ex_lsu_pc       = pc;
      bus.ex_lsu_inst     = pc + 32'h13;
      @(negedge clk);
      bus.ex_lsu_valid    = 1'b0;
      bus.ex_lsu_MemRead  = 1'b0;
      bus.ex_lsu_MemWrite = 1'b0;
   endtask

   // cycles from the accept edge to lsu_wb_valid, bounded
   task automatic wait_wb(output int lat);
      lat = 1;
      while (!bus.lsu_wb_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check("wb_valid_seen", 32'(bus.lsu_wb_valid), 32'd1);
   endtask

   task automatic wait_state(input logic [1:0] s);
      int n = 0;
      while (dbg_state !== s && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_state", 32'(dbg_state), 32'(s));
   endtask

   // compares the writeback data against the scoreboard and lets DONE drain
   task automatic retire(input string tag);
      check({tag, "_rd_data"}, bus.lsu_wb_write_rd_data, exp_q.pop_front());
      @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   logic [2:0]  t_len  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
   logic [31:0] t_addr [4] = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000002};
   logic [31:0] t_exp  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011};

   initial begin
      int lat;
      int rc;
      int rv;
      int se;
      int wc;

      bus.ex_lsu_valid = 1'b0;  bus.ex_lsu_MemRead = 1'b0; bus.ex_lsu_MemWrite = 1'b0;
      bus.ex_lsu_RegWrite = 1'b0; bus.ex_lsu_MemLen = 3'b000; bus.ex_lsu_rd = 5'd0;
      bus.addr = 32'h0; bus.data_in = 32'h0; bus.ex_lsu_result = 32'h0;
      bus.ex_lsu_pc = 32'h0; bus.ex_lsu_inst = 32'h0; bus.ex_flush = 1'b0;
      bus.wb_lsu_ready = 1'b1;

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ex_ready",  32'(bus.lsu_ex_ready),   32'd1);
      check("rst_state",     32'(dbg_state),          32'd0);
      check("rst_wb_valid",  32'(bus.lsu_wb_valid),   32'd0);
      check("rst_req_valid", 32'(bus.mem_req_valid),  32'd0);
      check("rst_resp_rdy",  32'(bus.mem_resp_ready), 32'd0);
      check("rst_wb_data",   bus.lsu_wb_write_rd_data, 32'h0);
      check("rst_fwd_rd",    32'(bus.lsu_ex_forward_rd), 32'd0);
      rst = 1'b0;

      // non-memory op: one cycle accept-to-valid
      exp_q.push_back(32'h12345678);
      send(1'b0, 1'b0, 1'b1, 3'b010, 5'd5, 32'h0, 32'h0, 32'h12345678, 32'h100);
      wait_wb(lat);
      check("alu_latency",  lat, 1);
      check("alu_regwrite", 32'(bus.lsu_wb_RegWrite), 32'd1);
      check("alu_rd",       32'(bus.lsu_wb_rd), 32'd5);
      check("alu_pc",       bus.lsu_wb_pc, 32'h100);
      check("alu_inst",     bus.lsu_wb_inst, 32'h113);
      check("alu_exc",      32'(bus.lsu_wb_exc), 32'd0);
      check("alu_fwd_rd",   32'(bus.lsu_ex_forward_rd), 32'd5);
      retire("alu");

      // lw, zero-wait bus: three cycles
      resp_data = 32'hDEADBEEF;
      rc = req_count;
      exp_q.push_back(32'hDEADBEEF);
      send(1'b1, 1'b0, 1'b1, 3'b010, 5'd10, 32'h80000004, 32'h0, 32'h0, 32'h104);
      wait_wb(lat);
      check("lw_latency",  lat, 3);
      check("lw_regwrite", 32'(bus.lsu_wb_RegWrite), 32'd1);
      check("lw_rd",       32'(bus.lsu_wb_rd), 32'd10);
      check("lw_exc",      32'(bus.lsu_wb_exc), 32'd0);
      check("lw_req_cnt",  req_count - rc, 1);
      check("lw_req_addr", last_addr, 32'h80000004);
      check("lw_req_we",   32'(last_we), 32'd0);
      check("lw_req_strb", 32'(last_wstrb), 32'd0);
      retire("lw");

      // byte/half loads with sign and zero extension
      resp_data = 32'h80112233;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(t_exp[i]);
         send(1'b1, 1'b0, 1'b1, t_len[i], 5'd11, t_addr[i], 32'h0, 32'h0, 32'h200);
         wait_wb(lat);
         check("ext_latency", lat, 3);
         retire($sformatf("ext%0d", i));
      end

      // sh at offset 2: upper lanes
      exp_q.push_back(32'h0);
      send(1'b0, 1'b1, 1'b0, 3'b001, 5'd0, 32'h00000002, 32'h0000ABCD, 32'h0, 32'h300);
      wait_wb(lat);
      check("sh_latency",  lat, 3);
      check("sh_req_addr", last_addr, 32'h0);
      check("sh_wdata",    last_wdata, 32'hABCD0000);
      check("sh_wstrb",    32'(last_wstrb), 32'hC);
      check("sh_we",       32'(last_we), 32'd1);
      check("sh_regwrite", 32'(bus.lsu_wb_RegWrite), 32'd0);
      retire("sh");

      // misaligned lw traps without a bus request
      rv = req_valid_cycles;
      exp_q.push_back(32'h0);
      send(1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h00000006, 32'h0, 32'h0, 32'h304);
      wait_wb(lat);
      check("mis_latency",  lat, 1);
      check("mis_exc",      32'(bus.lsu_wb_exc), 32'd1);
      check("mis_cause",    32'(bus.lsu_wb_cause), 32'd4);
      check("mis_tval",     bus.lsu_wb_tval, 32'h6);
      check("mis_regwrite", 32'(bus.lsu_wb_RegWrite), 32'd0);
      check("mis_no_req",   req_valid_cycles - rv, 0);
      retire("mis");

      // illegal lengths: load -> 4, store -> 6
      exp_q.push_back(32'h0);
      send(1'b1, 1'b0, 1'b1, 3'b011, 5'd3, 32'h00000000, 32'h0, 32'h0, 32'h308);
      wait_wb(lat);
      check("ill_ld_cause", 32'(bus.lsu_wb_cause), 32'd4);
      check("ill_ld_exc",   32'(bus.lsu_wb_exc), 32'd1);
      retire("ill_ld");
      exp_q.push_back(32'h0);
      send(1'b0, 1'b1, 1'b0, 3'b111, 5'd0, 32'h00000010, 32'h55, 32'h0, 32'h30C);
      wait_wb(lat);
      check("ill_st_cause", 32'(bus.lsu_wb_cause), 32'd6);
      check("ill_st_tval",  bus.lsu_wb_tval, 32'h10);
      retire("ill_st");

      // sw with a 5-cycle request stall and an error response
      stall_cfg = 5;
      resp_err  = 1'b1;
      rv = req_valid_cycles;
      se = stab_err;
      exp_q.push_back(32'h0);
      send(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h00000100, 32'h11223344, 32'h0, 32'h400);
      wait_wb(lat);
      check("sw_latency",    lat, 8);
      check("sw_valid_cyc",  req_valid_cycles - rv, 6);
      check("sw_stable",     stab_err - se, 0);
      check("sw_wdata",      last_wdata, 32'h11223344);
      check("sw_wstrb",      32'(last_wstrb), 32'hF);
      check("sw_exc",        32'(bus.lsu_wb_exc), 32'd1);
      check("sw_cause",      32'(bus.lsu_wb_cause), 32'd7);
      check("sw_tval",       bus.lsu_wb_tval, 32'h100);
      check("sw_regwrite",   32'(bus.lsu_wb_RegWrite), 32'd0);
      retire("sw_err");
      stall_cfg = 0;
      resp_err  = 1'b0;

      // writeback stalled 3 cycles in DONE, then flushed
      bus.wb_lsu_ready = 1'b0;
      send(1'b0, 1'b0, 1'b1, 3'b010, 5'd7, 32'h0, 32'h0, 32'hCAFEF00D, 32'h500);
      wait_wb(lat);
      check("hold_latency", lat, 1);
      for (int i = 0; i < 3; i++) begin
         check("hold_valid", 32'(bus.lsu_wb_valid), 32'd1);
         check("hold_data",  bus.lsu_wb_write_rd_data, 32'hCAFEF00D);
         check("hold_rd",    32'(bus.lsu_wb_rd), 32'd7);
         check("hold_ready", 32'(bus.lsu_ex_ready), 32'd0);
         @(negedge clk);
      end
      bus.ex_flush = 1'b1;
      @(negedge clk);
      bus.ex_flush = 1'b0;
      bus.wb_lsu_ready = 1'b1;
      check("flush_done_valid", 32'(bus.lsu_wb_valid), 32'd0);
      check("flush_done_state", 32'(dbg_state), 32'd0);

      // flush in REQ before the bus takes the request
      stall_cfg = 10;
      rc = req_count;
      send(1'b1, 1'b0, 1'b1, 3'b010, 5'd9, 32'h00000020, 32'h0, 32'h0, 32'h600);
      check("req_state",     32'(dbg_state), 32'd1);
      check("req_valid",     32'(bus.mem_req_valid), 32'd1);
      check("req_ex_ready",  32'(bus.lsu_ex_ready), 32'd0);
      check("req_fwd_rd",    32'(bus.lsu_ex_forward_rd), 32'd9);
      check("req_fwd_mrd",   32'(bus.lsu_ex_forward_MemRead), 32'd1);
      check("req_fwd_rw",    32'(bus.lsu_ex_forward_RegWrite), 32'd1);
      bus.ex_flush = 1'b1;
      @(negedge clk);
      bus.ex_flush = 1'b0;
      check("freq_state",    32'(dbg_state), 32'd0);
      check("freq_req_vld",  32'(bus.mem_req_valid), 32'd0);
      check("freq_wb_vld",   32'(bus.lsu_wb_valid), 32'd0);
      check("freq_fwd_rd",   32'(bus.lsu_ex_forward_rd), 32'd0);
      check("freq_no_hs",    req_count - rc, 0);
      stall_cfg = 0;

      // flush in RESP: response still consumed, no writeback
      resp_hold = 1'b1;
      wc = wb_cycles;
      rc = req_count;
      send(1'b1, 1'b0, 1'b1, 3'b010, 5'd4, 32'h00000030, 32'h0, 32'h0, 32'h700);
      wait_state(2'd2);
      bus.ex_flush = 1'b1;
      @(negedge clk);
      bus.ex_flush = 1'b0;
      check("fresp_still",   32'(dbg_state), 32'd2);
      check("fresp_rdy",     32'(bus.mem_resp_ready), 32'd1);
      resp_hold = 1'b0;
      wait_state(2'd0);
      check("fresp_no_wb",   wb_cycles - wc, 0);
      check("fresp_one_req", req_count - rc, 1);

      // reset while waiting for a response
      resp_hold = 1'b1;
      send(1'b1, 1'b0, 1'b1, 3'b010, 5'd6, 32'h00000040, 32'h0, 32'h0, 32'h800);
      wait_state(2'd2);
      rst = 1'b1;
      @(negedge clk);
      check("rrst_ex_ready", 32'(bus.lsu_ex_ready), 32'd1);
      check("rrst_state",    32'(dbg_state), 32'd0);
      check("rrst_resp_rdy", 32'(bus.mem_resp_ready), 32'd0);
      check("rrst_wb_valid", 32'(bus.lsu_wb_valid), 32'd0);
      check("rrst_fwd_mrd",  32'(bus.lsu_ex_forward_MemRead), 32'd0);
      rst = 1'b0;
      resp_hold = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
